uart_mmio: RTL and testbench

Memory-mapped UART peripheral between the single-cycle MIPS datapath's data-memory bus and the serial pins. It replaces the derived baud and sample clocks with enable ticks on the single system clock. It buffers CPU writes in a small TX FIFO, serialises them 8N1, and deserialises incoming frames into an RX holding register. It also exposes status bits and an interrupt request to the CPU.

---
 rtl/uart_mmio.sv | 207 ++++++++++++++++++++
 tb/tb_uart_mmio.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_mmio.sv
// Memory-mapped 8N1 UART for the single-cycle MIPS data bus: TX FIFO, RX holding register,
// status/control register and level interrupt, all timed by a 16x oversample tick on sysclk.
`timescale 1ns/1ps
module uart_mmio #(
    parameter int CLK_FREQ   = 100000000,
    parameter int BAUD       = 9600,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        sysclk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        MemRead,
    input  logic        MemWrite,
    output logic [31:0] rdata,
    input  logic        PC_Uart_rxd,
    output logic        PC_Uart_txd,
    output logic        irq
);
    localparam int DIV = CLK_FREQ / (BAUD * 16);
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int PW  = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    logic          sel_txd, sel_rxd, sel_con;
    logic          push, rd_rxd, con_wr;
    logic [CW-1:0] tick_cnt;
    logic          tick;
    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0]   fifo_cnt;
    logic          fifo_full, fifo_empty, tx_pop;
    tx_state_t     tx_state;
    logic [3:0]    tx_sub;
    logic [2:0]    tx_bit;
    logic [7:0]    tx_shift;
    rx_state_t     rx_state;
    logic          rx_s1, rx_s2;
    logic [3:0]    rx_sub;
    logic [2:0]    rx_bit;
    logic [7:0]    rx_shift, rx_byte;
    logic          rx_valid, overrun, ferr;
    logic          tx_ie, rx_ie;
    logic          tx_empty_idle;
    logic          unused_wdata;

    assign sel_txd       = (addr == 32'h4000_0018);
    assign sel_rxd       = (addr == 32'h4000_001C);
    assign sel_con       = (addr == 32'h4000_0020);
    assign push          = MemWrite & sel_txd & ~fifo_full;
    assign rd_rxd        = MemRead & sel_rxd;
    assign con_wr        = MemWrite & sel_con;
    assign tick          = (tick_cnt == CW'(DIV - 1));
    assign fifo_full     = (fifo_cnt == (PW+1)'(FIFO_DEPTH));
    assign fifo_empty    = (fifo_cnt == '0);
    assign tx_empty_idle = fifo_empty & (tx_state == TX_IDLE);
    assign unused_wdata  = ^wdata[31:7];

    // The FSM consumes the head entry on exactly these ticks; the FIFO pointers follow this.
    assign tx_pop = tick & ~fifo_empty &
                    ((tx_state == TX_IDLE) | ((tx_state == TX_STOP) & (tx_sub == 4'd15)));

    always_ff @(posedge sysclk) begin
        if (reset || tick) tick_cnt <= '0;
        else               tick_cnt <= tick_cnt + CW'(1);
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= wdata[7:0];
                wr_ptr           <= wr_ptr + PW'(1);
            end
            if (tx_pop) rd_ptr <= rd_ptr + PW'(1);
            if (push && !tx_pop)      fifo_cnt <= fifo_cnt + (PW+1)'(1);
            else if (!push && tx_pop) fifo_cnt <= fifo_cnt - (PW+1)'(1);
        end
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            tx_state    <= TX_IDLE;
            PC_Uart_txd <= 1'b1;
            tx_sub      <= '0;
            tx_bit      <= '0;
            tx_shift    <= '0;
        end else if (tick) begin
            case (tx_state)
                TX_IDLE: if (tx_pop) begin
                    tx_state    <= TX_START;
                    PC_Uart_txd <= 1'b0;
                    tx_sub      <= '0;
                    tx_shift    <= fifo_mem[rd_ptr];
                end
                TX_START: if (tx_sub == 4'd15) begin
                    tx_state    <= TX_DATA;
                    PC_Uart_txd <= tx_shift[0];
                    tx_sub      <= '0;
                    tx_bit      <= '0;
                end else tx_sub <= tx_sub + 4'd1;
                TX_DATA: if (tx_sub == 4'd15) begin
                    tx_sub <= '0;
                    if (tx_bit == 3'd7) begin
                        tx_state    <= TX_STOP;
                        PC_Uart_txd <= 1'b1;
                    end else begin
                        tx_bit      <= tx_bit + 3'd1;
                        tx_shift    <= {1'b0, tx_shift[7:1]};
                        PC_Uart_txd <= tx_shift[1];
                    end
                end else tx_sub <= tx_sub + 4'd1;
                TX_STOP: if (tx_sub == 4'd15) begin
                    tx_sub <= '0;
                    if (tx_pop) begin
                        tx_state    <= TX_START;
                        PC_Uart_txd <= 1'b0;
                        tx_shift    <= fifo_mem[rd_ptr];
                    end else tx_state <= TX_IDLE;
                end else tx_sub <= tx_sub + 4'd1;
                default: tx_state <= TX_IDLE;
            endcase
        end
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
        end else begin
            rx_s1 <= PC_Uart_rxd;
            rx_s2 <= rx_s1;
        end
    end

    // Flag clears come first so a same-cycle frame completion overrides them.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            rx_state <= RX_IDLE;
            rx_sub   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
            rx_byte  <= '0;
            rx_valid <= 1'b0;
            overrun  <= 1'b0;
            ferr     <= 1'b0;
        end else begin
            if (rd_rxd)               rx_valid <= 1'b0;
            if (con_wr && wdata[5])   overrun  <= 1'b0;
            if (con_wr && wdata[6])   ferr     <= 1'b0;
            if (tick) begin
                case (rx_state)
                    RX_IDLE: if (!rx_s2) begin
                        rx_state <= RX_START;
                        rx_sub   <= '0;
                    end
                    RX_START: if (rx_sub == 4'd7) begin
                        rx_sub <= '0;
                        rx_bit <= '0;
                        rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
                    end else rx_sub <= rx_sub + 4'd1;
                    RX_DATA: if (rx_sub == 4'd15) begin
                        rx_sub   <= '0;
                        rx_shift <= {rx_s2, rx_shift[7:1]};
                        if (rx_bit == 3'd7) rx_state <= RX_STOP;
                        else                rx_bit   <= rx_bit + 3'd1;
                    end else rx_sub <= rx_sub + 4'd1;
                    RX_STOP: if (rx_sub == 4'd15) begin
                        rx_sub   <= '0;
                        rx_state <= RX_IDLE;
                        if (rx_s2) begin
                            rx_byte  <= rx_shift;
                            rx_valid <= 1'b1;
                            if (rx_valid && !rd_rxd) overrun <= 1'b1;
                        end else ferr <= 1'b1;
                    end else rx_sub <= rx_sub + 4'd1;
                    default: rx_state <= RX_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            tx_ie <= 1'b0;
            rx_ie <= 1'b0;
            irq   <= 1'b0;
        end else begin
            if (con_wr) begin
                tx_ie <= wdata[0];
                rx_ie <= wdata[1];
            end
            irq <= (tx_ie & ~fifo_full) | (rx_ie & rx_valid);
        end
    end

    always_comb begin
        rdata = '0;
        if (sel_rxd) rdata = {24'b0, rx_byte};
        if (sel_con) rdata = {25'b0, ferr, overrun, rx_valid, tx_empty_idle, fifo_full, rx_ie, tx_ie};
    end
endmodule

// File: tb/tb_uart_mmio.sv
// Scoreboard bench for uart_mmio at DIV=10 (160 cycles per bit): TX frames decoded off the pin,
// RX frames driven onto the pin, register reads compared against bench-side expectations.
`timescale 1ns/1ps
module tb_uart_mmio;
    localparam int CLK_FREQ = 1600000;
    localparam int BAUD     = 10000;
    localparam int BIT      = 160;
    localparam logic [31:0] A_TXD = 32'h4000_0018;
    localparam logic [31:0] A_RXD = 32'h4000_001C;
    localparam logic [31:0] A_CON = 32'h4000_0020;

    logic        sysclk = 1'b0;
    logic        reset, MemRead, MemWrite, PC_Uart_rxd, PC_Uart_txd, irq;
    logic [31:0] addr, wdata, rdata;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    logic [7:0]  tx_q [$];
    logic [7:0]  rx_q [$];
    int          starts [$];
    bit          mon_en;
    int          mon_t0;
    logic [7:0]  mon_b;
    logic [31:0] d;
    int          n, found;

    uart_mmio #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .FIFO_DEPTH(4)) dut (
        .sysclk(sysclk), .reset(reset), .addr(addr), .wdata(wdata),
        .MemRead(MemRead), .MemWrite(MemWrite), .rdata(rdata),
        .PC_Uart_rxd(PC_Uart_rxd), .PC_Uart_txd(PC_Uart_txd), .irq(irq)
    );

    always #5 sysclk = ~sysclk;
    always @(posedge sysclk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Bus tasks are entered on a negedge and return on the following negedge.
    task automatic bus_write(input logic [31:0] a, input logic [31:0] v);
        addr = a; wdata = v; MemWrite = 1'b1;
        @(negedge sysclk);
        MemWrite = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] v);
        addr = a; MemRead = 1'b1;
        #1 v = rdata;
        @(negedge sysclk);
        MemRead = 1'b0;
    endtask

    task automatic idle(input int c);
        repeat (c) @(negedge sysclk);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit stop_ok);
        if (stop_ok) rx_q.push_back(b);
        PC_Uart_rxd = 1'b0;
        idle(BIT);
        for (int i = 0; i < 8; i++) begin
            PC_Uart_rxd = b[i];
            idle(BIT);
        end
        PC_Uart_rxd = stop_ok;
        idle(stop_ok ? BIT : 100);
        PC_Uart_rxd = 1'b1;
        idle(BIT);
    endtask

    // TX line monitor: decodes each frame at mid-bit and scores it against tx_q.
    initial begin
        forever begin
            @(negedge sysclk);
            if (mon_en && PC_Uart_txd === 1'b0) begin
                mon_t0 = cyc;
                starts.push_back(mon_t0);
                idle(BIT/2);
                check("tx_start_bit", {31'b0, PC_Uart_txd}, 32'd0);
                for (int i = 0; i < 8; i++) begin
                    idle(BIT);
                    mon_b[i] = PC_Uart_txd;
                end
                idle(BIT);
                check("tx_stop_bit", {31'b0, PC_Uart_txd}, 32'd1);
                if (tx_q.size() == 0) check("tx_spurious_frame", 32'(tx_q.size()), 32'd1);
                else                  check("tx_byte", {24'b0, mon_b}, {24'b0, tx_q.pop_front()});
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; addr = '0; wdata = '0; MemRead = 1'b0; MemWrite = 1'b0;
        PC_Uart_rxd = 1'b1; mon_en = 1'b1;
        idle(3);
        check("reset_txd", {31'b0, PC_Uart_txd}, 32'd1);
        check("reset_irq", {31'b0, irq}, 32'd0);
        reset = 1'b0;
        bus_read(A_CON, d);         check("reset_con", d, 32'h08);
        bus_read(A_TXD, d);         check("txd_reads_zero", d, 32'h0);
        bus_read(32'h4000_0024, d); check("unselected_zero", d, 32'h0);

        // Single frame 0x55: exact start-bit length and busy/idle status.
        tx_q.push_back(8'h55);
        bus_write(A_TXD, 32'h55);
        n = 0;
        while (PC_Uart_txd && n < 100) begin idle(1); n++; end
        n = 0;
        while (!PC_Uart_txd && n < 400) begin idle(1); n++; end
        check("tx_start_len", n, BIT);
        bus_read(A_CON, d);         check("con_tx_busy", d, 32'h00);
        idle(1600);
        bus_read(A_CON, d);         check("con_tx_done", d, 32'h08);

        // Burst aligned just before a tick so the first pop lands 10 cycles after the first write.
        starts.delete();
        n = 0;
        while (!dut.tick && n < 20) begin idle(1); n++; end
        tx_q.push_back(8'h11); tx_q.push_back(8'h22); tx_q.push_back(8'h33); tx_q.push_back(8'h44);
        bus_write(A_TXD, 32'h11);
        bus_write(A_TXD, 32'h22);
        bus_write(A_TXD, 32'h33);
        bus_write(A_TXD, 32'h44);
        bus_read(A_CON, d);         check("con_fifo_full", d, 32'h04);
        bus_write(A_TXD, 32'h66);
        idle(5);
        bus_read(A_CON, d);         check("con_after_first_pop", d, 32'h00);
        idle(4*1600 + 200);
        check("burst_frames", 32'(starts.size()), 32'd4);
        for (int i = 1; i < 4 && i < starts.size(); i++)
            check("burst_gap", 32'(starts[i] - starts[i-1]), 32'd1600);
        check("tx_q_drained", 32'(tx_q.size()), 32'd0);

        // Receive 0xA3.
        send_frame(8'hA3, 1'b1);
        bus_read(A_CON, d);         check("con_rx_valid", d, 32'h18);
        bus_read(A_RXD, d);         check("rxd_byte", d, {24'b0, rx_q.pop_front()});
        bus_read(A_CON, d);         check("con_rx_cleared", d, 32'h08);

        // Overrun, with tx_ie driving irq meanwhile.
        bus_write(A_CON, 32'h01);
        idle(1);
        check("irq_tx_ie", {31'b0, irq}, 32'd1);
        send_frame(8'h01, 1'b1);
        send_frame(8'h02, 1'b1);
        bus_read(A_CON, d);         check("con_overrun", d, 32'h39);
        bus_write(A_CON, 32'h20);
        bus_read(A_CON, d);         check("con_overrun_clr", d, 32'h18);
        bus_read(A_RXD, d);         check("rxd_overrun_byte", d, {24'b0, rx_q[rx_q.size()-1]});
        rx_q.delete();
        bus_read(A_CON, d);         check("con_after_ovr_read", d, 32'h08);
        check("irq_tx_ie_off", {31'b0, irq}, 32'd0);

        // Framing error, then a short glitch, then a clean frame.
        send_frame(8'h5A, 1'b0);
        bus_read(A_CON, d);         check("con_ferr", d, 32'h48);
        bus_write(A_CON, 32'h40);
        bus_read(A_CON, d);         check("con_ferr_clr", d, 32'h08);
        PC_Uart_rxd = 1'b0; idle(3); PC_Uart_rxd = 1'b1; idle(400);
        bus_read(A_CON, d);         check("con_after_glitch", d, 32'h08);
        send_frame(8'hC5, 1'b1);
        bus_read(A_CON, d);         check("con_after_glitch_rx", d, 32'h18);
        bus_read(A_RXD, d);         check("rxd_after_glitch", d, {24'b0, rx_q.pop_front()});

        // irq follows rx_valid by exactly one cycle.
        bus_write(A_CON, 32'h02);
        found = 0;
        fork
            send_frame(8'h3C, 1'b1);
            begin
                addr = A_CON; MemRead = 1'b1;
                for (int i = 0; i < 2500 && found == 0; i++) begin
                    #1;
                    if (rdata[4]) begin
                        found = 1;
                        check("irq_before_latency", {31'b0, irq}, 32'd0);
                        @(negedge sysclk);
                        #1 check("irq_after_latency", {31'b0, irq}, 32'd1);
                    end else @(negedge sysclk);
                end
                MemRead = 1'b0;
            end
        join
        check("rx_valid_seen", found, 32'd1);
        bus_read(A_RXD, d);         check("rxd_irq_byte", d, {24'b0, rx_q.pop_front()});
        check("irq_hold", {31'b0, irq}, 32'd1);
        idle(1);
        check("irq_drop", {31'b0, irq}, 32'd0);

        // Reset in the middle of a data bit with a second byte still queued.
        mon_en = 1'b0;
        bus_write(A_CON, 32'h01);
        bus_write(A_TXD, 32'h00);
        bus_write(A_TXD, 32'h00);
        idle(400);
        check("tx_mid_data", {31'b0, PC_Uart_txd}, 32'd0);
        check("irq_before_reset", {31'b0, irq}, 32'd1);
        reset = 1'b1;
        @(posedge sysclk);
        #1;
        check("reset_mid_txd", {31'b0, PC_Uart_txd}, 32'd1);
        check("reset_mid_irq", {31'b0, irq}, 32'd0);
        @(negedge sysclk);
        reset = 1'b0;
        bus_read(A_CON, d);         check("con_after_reset", d, 32'h08);
        n = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge sysclk);
            if (!PC_Uart_txd) n++;
        end
        check("fifo_discarded", n, 32'd0);
        check("rx_q_drained", 32'(rx_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
